// File: rtl/dot_product_operand_feeder.sv
// -----------------------------------------------------------------------------
// dot_product_operand_feeder
//
// Sequencer that drives the dot-product unit (DPU). The host fills three local
// banks (A vectors, B vectors, bias vector) and issues go. The feeder then
// resets and starts the DPU, presents one A/B vector pair per systolic pass,
// advancing on each rising edge of dpu_array_done_i, captures the ReLU result
// after dpu_done_i and hands it back to the host over a valid/ready handshake.
//
// Optional build macro: FEEDER_TIMEOUT_EN
//   Adds parameter TIMEOUT_CYCLES and output err_timeout_o. A watchdog aborts
//   the job (no result, one-cycle dpu_reset_o) when FEED/WAIT_DONE makes no
//   progress for TIMEOUT_CYCLES cycles. Without the macro the feeder waits
//   indefinitely.
//
// Ports
//   clk_i, reset_i          clock; synchronous active-low reset
//   wr_en_i/sel/addr/data   host bank writes (sel 0=A, 1=B, 2=bias, 3=ignored),
//                           dropped while busy_o=1
//   go_i, cfg_length_i,     job request with pass count and lane mask
//   cfg_active_units_i
//   busy_o, err_len_o       job in flight; one-cycle pulse on a rejected go
//   dpu_*_o                 DPU control, latched config and operand vectors
//   dpu_array_done_i,       DPU pass-complete level, adder-ready, ReLU result
//   dpu_done_i, dpu_relu_out_i
//   res_valid_o/ready_i/data_o  result handshake to the host
// -----------------------------------------------------------------------------
module dot_product_operand_feeder #(
   parameter int DATA_WIDTH = 16,
   parameter int NUM_UNITS  = 4,
   parameter int MAX_LEN    = 16
`ifdef FEEDER_TIMEOUT_EN
   ,
   parameter int TIMEOUT_CYCLES = 1024
`endif
   ,
   localparam int LEN_W  = $clog2(MAX_LEN + 1),
   localparam int ADDR_W = $clog2(MAX_LEN),
   localparam int VEC_W  = NUM_UNITS * DATA_WIDTH
) (
   input  logic                 clk_i,
   input  logic                 reset_i,
   input  logic                 wr_en_i,
   input  logic [1:0]           wr_sel_i,
   input  logic [ADDR_W-1:0]    wr_addr_i,
   input  logic [VEC_W-1:0]     wr_data_i,
   input  logic                 go_i,
   input  logic [LEN_W-1:0]     cfg_length_i,
   input  logic [NUM_UNITS-1:0] cfg_active_units_i,
   output logic                 busy_o,
   output logic                 err_len_o,
   output logic                 dpu_reset_o,
   output logic                 dpu_start_o,
   output logic [NUM_UNITS-1:0] dpu_active_units_o,
   output logic [LEN_W-1:0]     dpu_length_o,
   output logic [VEC_W-1:0]     dpu_a_array_o,
   output logic [VEC_W-1:0]     dpu_b_array_o,
   output logic [VEC_W-1:0]     dpu_bias_array_o,
   input  logic                 dpu_array_done_i,
   input  logic                 dpu_done_i,
   input  logic [VEC_W-1:0]     dpu_relu_out_i,
   output logic                 res_valid_o,
   input  logic                 res_ready_i,
   output logic [VEC_W-1:0]     res_data_o
`ifdef FEEDER_TIMEOUT_EN
   ,
   output logic                 err_timeout_o
`endif
);

   typedef enum logic [2:0] {
      IDLE, DPU_RST, ISSUE, FEED, WAIT_DONE, CAPTURE, RESULT
   } state_e;

   state_e                 state_q;
   logic [ADDR_W-1:0]      idx_q;
   logic [ADDR_W-1:0]      idx_d;
   logic [LEN_W-1:0]       length_q;
   logic [NUM_UNITS-1:0]   mask_q;
   logic [VEC_W-1:0]       a_q, b_q, res_q;
   logic                   busy_q, err_len_q, dpu_reset_q, dpu_start_q, res_valid_q;
   logic                   done_prev_q;
   logic                   array_rise;
   logic                   last_pass;
   logic                   len_ok;

   logic [VEC_W-1:0]       a_bank [MAX_LEN];
   logic [VEC_W-1:0]       b_bank [MAX_LEN];
   logic [VEC_W-1:0]       bias_q;

   // A pass completes on the 0->1 transition only; a level held high across
   // several cycles counts once.
   assign array_rise = dpu_array_done_i & ~done_prev_q;
   assign idx_d      = idx_q + ADDR_W'(1);
   assign last_pass  = (LEN_W'(idx_q) == (length_q - LEN_W'(1)));
   assign len_ok     = (cfg_length_i != '0) && (cfg_length_i <= LEN_W'(MAX_LEN));

   // NOTE: the operand banks are plain storage with no reset term, so they map
   // onto RAM/register-file cells and keep their contents across a reset.
   always_ff @(posedge clk_i) begin
      if (wr_en_i && !busy_q) begin
         case (wr_sel_i)
            2'd0:    a_bank[wr_addr_i] <= wr_data_i;
            2'd1:    b_bank[wr_addr_i] <= wr_data_i;
            2'd2:    bias_q            <= wr_data_i;
            default: ;
         endcase
      end
   end

`ifdef FEEDER_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic             err_timeout_q;
   assign cnt_d         = cnt_q + CNT_W'(1);
   assign err_timeout_o = err_timeout_q;
`endif

   // NOTE: every register here is sequential state, so each is written with a
   // non-blocking assignment; the pulse defaults at the top are overridden by
   // later assignments in the same edge.
   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         length_q    <= '0;
         mask_q      <= '0;
         a_q         <= '0;
         b_q         <= '0;
         res_q       <= '0;
         busy_q      <= 1'b0;
         err_len_q   <= 1'b0;
         dpu_reset_q <= 1'b1;
         dpu_start_q <= 1'b0;
         res_valid_q <= 1'b0;
         done_prev_q <= 1'b0;
`ifdef FEEDER_TIMEOUT_EN
         cnt_q         <= '0;
         err_timeout_q <= 1'b0;
`endif
      end else begin
         err_len_q   <= 1'b0;
         dpu_reset_q <= 1'b0;
         dpu_start_q <= 1'b0;
         done_prev_q <= dpu_array_done_i;

         case (state_q)
            IDLE: begin
               if (go_i) begin
                  if (len_ok) begin
                     length_q    <= cfg_length_i;
                     mask_q      <= cfg_active_units_i;
                     idx_q       <= '0;
                     busy_q      <= 1'b1;
                     dpu_reset_q <= 1'b1;
                     state_q     <= DPU_RST;
                  end else begin
                     err_len_q <= 1'b1;
                  end
               end
            end
            DPU_RST: begin
               // Operands for pass 0 are in place when the DPU sees start.
               a_q         <= a_bank[0];
               b_q         <= b_bank[0];
               dpu_start_q <= 1'b1;
               state_q     <= ISSUE;
            end
            ISSUE: state_q <= FEED;
            FEED: begin
               if (array_rise) begin
                  if (last_pass) begin
                     state_q <= WAIT_DONE;
                  end else begin
                     idx_q <= idx_d;
                     a_q   <= a_bank[idx_d];
                     b_q   <= b_bank[idx_d];
                  end
               end
            end
            WAIT_DONE: if (dpu_done_i) state_q <= CAPTURE;
            CAPTURE: begin
               // ReLU output is registered in the DPU, valid one cycle after done.
               res_q       <= dpu_relu_out_i;
               res_valid_q <= 1'b1;
               state_q     <= RESULT;
            end
            RESULT: begin
               if (res_ready_i) begin
                  res_valid_q <= 1'b0;
                  busy_q      <= 1'b0;
                  state_q     <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase

`ifdef FEEDER_TIMEOUT_EN
         err_timeout_q <= 1'b0;
         if (state_q == FEED || state_q == WAIT_DONE) begin
            if (array_rise) begin
               cnt_q <= '0;
            end else if (cnt_d == CNT_W'(TIMEOUT_CYCLES)) begin
               // Watchdog abort overrides whatever the case above decided.
               cnt_q         <= '0;
               err_timeout_q <= 1'b1;
               dpu_reset_q   <= 1'b1;
               busy_q        <= 1'b0;
               state_q       <= IDLE;
            end else begin
               cnt_q <= cnt_d;
            end
         end else begin
            cnt_q <= '0;
         end
`endif
      end
   end

   assign busy_o             = busy_q;
   assign err_len_o          = err_len_q;
   assign dpu_reset_o        = dpu_reset_q;
   assign dpu_start_o        = dpu_start_q;
   assign dpu_active_units_o = mask_q;
   assign dpu_length_o       = length_q;
   assign dpu_a_array_o      = a_q;
   assign dpu_b_array_o      = b_q;
   assign dpu_bias_array_o   = bias_q;
   assign res_valid_o        = res_valid_q;
   assign res_data_o         = res_q;

endmodule

// File: tb/tb_dot_product_operand_feeder.sv
// -----------------------------------------------------------------------------
// Self-checking bench for dot_product_operand_feeder. The bench plays both the
// host and the DPU: it keeps its own copy of the banks, computes the DPU
// result with plain arithmetic and checks sequencing, operand presentation,
// latencies and the result handshake.
// -----------------------------------------------------------------------------
module tb_dot_product_operand_feeder;

   localparam int DW = 16;
   localparam int NU = 4;
   localparam int ML = 16;
   localparam int LW = $clog2(ML + 1);
   localparam int AW = $clog2(ML);
   localparam int VW = DW * NU;

   logic          clk = 1'b0;
   logic          reset;
   logic          wr_en;
   logic [1:0]    wr_sel;
   logic [AW-1:0] wr_addr;
   logic [VW-1:0] wr_data;
   logic          go;
   logic [LW-1:0] cfg_length;
   logic [NU-1:0] cfg_active_units;
   logic          busy, err_len, dpu_reset, dpu_start;
   logic [NU-1:0] dpu_active_units;
   logic [LW-1:0] dpu_length;
   logic [VW-1:0] dpu_a_array, dpu_b_array, dpu_bias_array;
   logic          dpu_array_done, dpu_done;
   logic [VW-1:0] dpu_relu_out;
   logic          res_valid, res_ready;
   logic [VW-1:0] res_data;

   always #5 clk = ~clk;

   dot_product_operand_feeder dut (
      .clk_i              (clk),
      .reset_i            (reset),
      .wr_en_i            (wr_en),
      .wr_sel_i           (wr_sel),
      .wr_addr_i          (wr_addr),
      .wr_data_i          (wr_data),
      .go_i               (go),
      .cfg_length_i       (cfg_length),
      .cfg_active_units_i (cfg_active_units),
      .busy_o             (busy),
      .err_len_o          (err_len),
      .dpu_reset_o        (dpu_reset),
      .dpu_start_o        (dpu_start),
      .dpu_active_units_o (dpu_active_units),
      .dpu_length_o       (dpu_length),
      .dpu_a_array_o      (dpu_a_array),
      .dpu_b_array_o      (dpu_b_array),
      .dpu_bias_array_o   (dpu_bias_array),
      .dpu_array_done_i   (dpu_array_done),
      .dpu_done_i         (dpu_done),
      .dpu_relu_out_i     (dpu_relu_out),
      .res_valid_o        (res_valid),
      .res_ready_i        (res_ready),
      .res_data_o         (res_data)
   );

   // Host-side copy of the banks.
   logic [VW-1:0] ma [ML];
   logic [VW-1:0] mb [ML];
   logic [VW-1:0] mbias;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Inputs change and outputs are sampled 1ns after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // DPU behaviour: per enabled lane, signed sum over passes of a*b plus bias,
   // truncated to the element width, negatives clamped to zero.
   function automatic logic [VW-1:0] dpu_model(input int len, input logic [NU-1:0] mask);
      logic [VW-1:0] r;
      r = '0;
      for (int l = 0; l < NU; l++) begin
         longint acc;
         logic [63:0] acc_v;
         logic [DW-1:0] v;
         if (!mask[l]) continue;
         acc = longint'($signed(mbias[l*DW +: DW]));
         for (int p = 0; p < len; p++)
            acc += longint'($signed(ma[p][l*DW +: DW])) * longint'($signed(mb[p][l*DW +: DW]));
         acc_v = acc;
         v = acc_v[DW-1:0];
         r[l*DW +: DW] = v[DW-1] ? '0 : v;
      end
      return r;
   endfunction

   task automatic write_bank(input logic [1:0] sel, input int addr, input logic [VW-1:0] data);
      wr_en = 1'b1; wr_sel = sel; wr_addr = AW'(addr); wr_data = data;
      tick();
      wr_en = 1'b0;
      if (sel == 2'd0) ma[addr] = data;
      else if (sel == 2'd1) mb[addr] = data;
      else if (sel == 2'd2) mbias = data;
   endtask

   task automatic start_job(input int len, input logic [NU-1:0] mask);
      go = 1'b1; cfg_length = LW'(len); cfg_active_units = mask;
      tick();
      go = 1'b0;
      check("go_rst_pulse", dpu_reset, 1'b1);
      check("go_busy", busy, 1'b1);
      check("go_no_early_start", dpu_start, 1'b0);
      tick();
      check("start_at_2", dpu_start, 1'b1);
      check("rst_one_cycle", dpu_reset, 1'b0);
      check("latched_len", dpu_length, VW'(len));
      check("latched_mask", dpu_active_units, VW'(mask));
      check("a_pass0_at_start", dpu_a_array, ma[0]);
      check("b_pass0_at_start", dpu_b_array, mb[0]);
      tick();
      check("start_one_cycle", dpu_start, 1'b0);
   endtask

   task automatic run_job(input int len, input logic [NU-1:0] mask, input int hold,
                          input int ready_delay, input bit intrude);
      logic [VW-1:0] exp;
      int nxt;
      exp = dpu_model(len, mask);
      start_job(len, mask);
      for (int p = 0; p < len; p++) begin
         repeat ($urandom_range(0, 2)) tick();
         if (intrude && p == 0) begin
            go = 1'b1; cfg_length = LW'(5);
            wr_en = 1'b1; wr_sel = 2'd0; wr_addr = '0; wr_data = ~ma[0];
            tick();
            go = 1'b0; wr_en = 1'b0;
            check("busy_go_no_err", err_len, 1'b0);
            check("busy_go_len_kept", dpu_length, VW'(len));
            check("busy_go_busy", busy, 1'b1);
         end
         check("a_before_rise", dpu_a_array, ma[p]);
         check("b_before_rise", dpu_b_array, mb[p]);
         dpu_array_done = 1'b1;
         tick();
         nxt = (p < len - 1) ? p + 1 : p;
         check("a_after_rise", dpu_a_array, ma[nxt]);
         check("b_after_rise", dpu_b_array, mb[nxt]);
         if (hold > 1) begin
            repeat (hold - 1) tick();
            check("a_level_held", dpu_a_array, ma[nxt]);
         end
         dpu_array_done = 1'b0;
         tick();
      end
      repeat ($urandom_range(0, 2)) tick();
      check("no_valid_before_done", res_valid, 1'b0);
      dpu_done = 1'b1;
      tick();
      dpu_done = 1'b0;
      dpu_relu_out = exp;
      check("valid_not_at_1", res_valid, 1'b0);
      tick();
      dpu_relu_out = {$urandom(), $urandom()};
      check("valid_at_2", res_valid, 1'b1);
      check("res_data", res_data, exp);
      check("busy_in_result", busy, 1'b1);
      for (int i = 0; i < ready_delay; i++) begin
         tick();
         check("valid_stall", res_valid, 1'b1);
         check("data_stall", res_data, exp);
         check("busy_stall", busy, 1'b1);
      end
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      check("valid_cleared", res_valid, 1'b0);
      check("busy_cleared", busy, 1'b0);
      tick();
   endtask

   task automatic bad_go(input int len);
      go = 1'b1; cfg_length = LW'(len); cfg_active_units = 4'hF;
      tick();
      go = 1'b0;
      check("err_len_pulse", err_len, 1'b1);
      check("err_len_busy", busy, 1'b0);
      check("err_len_no_rst", dpu_reset, 1'b0);
      tick();
      check("err_len_one_cycle", err_len, 1'b0);
      check("err_len_no_start", dpu_start, 1'b0);
      tick();
      check("err_len_no_start2", dpu_start, 1'b0);
   endtask

   task automatic fill_random();
      for (int i = 0; i < ML; i++) begin
         write_bank(2'd0, i, {$urandom(), $urandom()});
         write_bank(2'd1, i, {$urandom(), $urandom()});
      end
      write_bank(2'd2, 0, {$urandom(), $urandom()});
      check("bias_follows_bank", dpu_bias_array, mbias);
   endtask

   initial begin
      reset = 1'b0; wr_en = 1'b0; wr_sel = '0; wr_addr = '0; wr_data = '0;
      go = 1'b0; cfg_length = '0; cfg_active_units = '0;
      dpu_array_done = 1'b0; dpu_done = 1'b0; dpu_relu_out = '0; res_ready = 1'b0;
      tick(); tick();
      check("rst_dpu_reset", dpu_reset, 1'b1);
      check("rst_busy", busy, 1'b0);
      check("rst_valid", res_valid, 1'b0);
      check("rst_start", dpu_start, 1'b0);
      check("rst_err_len", err_len, 1'b0);
      check("rst_res_data", res_data, '0);
      check("rst_a", dpu_a_array, '0);
      reset = 1'b1;
      tick();
      check("idle_dpu_reset_low", dpu_reset, 1'b0);

      // Directed job: A[p] lane l = (l+1)*(p+1), B all 2, bias 0.
      for (int p = 0; p < ML; p++) begin
         logic [VW-1:0] av, bv;
         for (int l = 0; l < NU; l++) begin
            av[l*DW +: DW] = DW'((l + 1) * (p + 1));
            bv[l*DW +: DW] = DW'(2);
         end
         write_bank(2'd0, p, av);
         write_bank(2'd1, p, bv);
      end
      write_bank(2'd2, 0, '0);
      write_bank(2'd3, 0, {4{16'h7FFF}});
      check("bias_sel3_ignored", dpu_bias_array, '0);
      check("directed_model", dpu_model(3, 4'hF), {16'd48, 16'd36, 16'd24, 16'd12});
      run_job(3, 4'hF, 1, 10, 1'b0);

      bad_go(0);
      bad_go(ML + 1);

      // Level held high: one advance per rise; go and writes while busy dropped.
      run_job(2, 4'hF, 5, 0, 1'b1);
      run_job(3, 4'h5, 5, 1, 1'b0);

      // Reset in FEED.
      start_job(4, 4'hF);
      dpu_array_done = 1'b1;
      tick();
      dpu_array_done = 1'b0;
      reset = 1'b0;
      tick();
      check("midrst_dpu_reset", dpu_reset, 1'b1);
      check("midrst_busy", busy, 1'b0);
      check("midrst_valid", res_valid, 1'b0);
      check("midrst_a", dpu_a_array, '0);
      check("midrst_len", dpu_length, '0);
      reset = 1'b1;
      tick();
      check("midrst_release", dpu_reset, 1'b0);
      // Banks survive reset.
      run_job(4, 4'hF, 1, 0, 1'b0);

      for (int j = 0; j < 6; j++) begin
         fill_random();
         run_job($urandom_range(1, ML), NU'($urandom()), $urandom_range(1, 3),
                 $urandom_range(0, 3), j == 2);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
